pkt_tx_arbiter: RTL and testbench

PKT_TX_ARBITER -- requirements
Module: pkt_tx_arbiter

---
 rtl/pkt_tx_arb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/pkt_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_pkt_tx_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_tx_arb_pkg.sv
// Shared types and constants for the packet transmit arbiter.
// The FSM state type, the MAC modulo width and the statistics counter width
// live here so the top level and its arbiter slice agree on them.
package pkt_tx_arb_pkg;

    localparam int MOD_W  = 3;
    localparam int STAT_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arbState_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin source selector for the packet transmit arbiter.
// Searches the request vector starting one position after the last winner,
// wrapping around, and reports the first requester found.
module rr_arbiter
    import pkt_tx_arb_pkg::*;
#(
    parameter int N_SRC = 2,
    parameter int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [IDX_W-1:0] lastGrant_i,
    output logic [IDX_W-1:0] grantIdx_o,
    output logic             grantValid_o
);

    int cand;

    // Walk the sources in rotated order and latch onto the first requester.
    always_comb begin
        grantIdx_o   = '0;
        grantValid_o = 1'b0;
        cand         = 0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = (int'(lastGrant_i) + 1 + k) % N_SRC;
            if (!grantValid_o && req_i[cand[IDX_W-1:0]]) begin
                grantValid_o = 1'b1;
                grantIdx_o   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pkt_tx_arbiter.sv
// Packet transmit arbiter: merges N_SRC packet sources onto one MAC transmit
// interface, one whole packet at a time, with round-robin fairness.
// Optional build macro PKT_TX_ARB_STATS_EN adds per-source packet counters
// on the stat_pkt_cnt port.
module pkt_tx_arbiter
    import pkt_tx_arb_pkg::*;
#(
    parameter int N_SRC  = 2,
    parameter int DATA_W = 64
) (
    input  logic                      clk_156m25,
    input  logic                      reset_156m25,
    input  logic [N_SRC-1:0]          src_val,
    input  logic [N_SRC-1:0]          src_sop,
    input  logic [N_SRC-1:0]          src_eop,
    input  logic [N_SRC*MOD_W-1:0]    src_mod,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    output logic [N_SRC-1:0]          src_rdy,
    output logic [DATA_W-1:0]         pkt_tx_data,
    output logic                      pkt_tx_sop,
    output logic                      pkt_tx_eop,
    output logic [MOD_W-1:0]          pkt_tx_mod,
    output logic                      pkt_tx_val,
    input  logic                      pkt_tx_full,
    output logic [$clog2(N_SRC)-1:0]  cur_grant,
`ifdef PKT_TX_ARB_STATS_EN
    output logic [N_SRC*STAT_W-1:0]   stat_pkt_cnt,
`endif
    output logic                      proto_err
);

    localparam int IDX_W = $clog2(N_SRC);

    arbState_t          state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   lastGrant_q, lastGrant_d;
    logic               firstBeat_q, firstBeat_d;
    logic               protoErr_q, protoErr_d;

    logic [DATA_W-1:0]  txData_q;
    logic               txSop_q, txEop_q, txVal_q;
    logic [MOD_W-1:0]   txMod_q;

    logic [N_SRC-1:0]   sopReq;
    logic [IDX_W-1:0]   arbIdx;
    logic               arbValid;
    logic [N_SRC-1:0]   rdy;
    logic               xfer;
    logic               selSop, selEop;
    logic [MOD_W-1:0]   selMod;
    logic [DATA_W-1:0]  selData;

    // Only a beat that opens a packet may compete for the output.
    assign sopReq = src_val & src_sop;

    rr_arbiter #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_rrArbiter (
        .req_i        (sopReq),
        .lastGrant_i  (lastGrant_q),
        .grantIdx_o   (arbIdx),
        .grantValid_o (arbValid)
    );

    // Next-state logic: pick a packet in IDLE, stream its beats in XFER.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        firstBeat_d = firstBeat_q;
        protoErr_d  = protoErr_q;
        rdy         = '0;
        xfer        = 1'b0;
        selSop      = src_sop[grant_q];
        selEop      = src_eop[grant_q];
        selMod      = src_mod[grant_q*MOD_W +: MOD_W];
        selData     = src_data[grant_q*DATA_W +: DATA_W];
        case (state_q)
            IDLE: begin
                if (|(src_val & ~src_sop)) begin
                    protoErr_d = 1'b1;
                end
                if (arbValid) begin
                    grant_d     = arbIdx;
                    firstBeat_d = 1'b1;
                    state_d     = XFER;
                end
            end
            XFER: begin
                rdy[grant_q] = !pkt_tx_full;
                xfer         = src_val[grant_q] && !pkt_tx_full;
                if (xfer) begin
                    firstBeat_d = 1'b0;
                    if (selSop && !firstBeat_q) begin
                        protoErr_d = 1'b1;
                    end
                    if (selEop) begin
                        state_d     = IDLE;
                        lastGrant_d = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is held low while reset is asserted so no beat is taken then.
    assign src_rdy = rdy & {N_SRC{!reset_156m25}};

    // Control state and the registered copy of each transferred beat.
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            lastGrant_q <= IDX_W'(N_SRC - 1);
            firstBeat_q <= 1'b0;
            protoErr_q  <= 1'b0;
            txData_q    <= '0;
            txSop_q     <= 1'b0;
            txEop_q     <= 1'b0;
            txMod_q     <= '0;
            txVal_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            firstBeat_q <= firstBeat_d;
            protoErr_q  <= protoErr_d;
            txVal_q     <= xfer;
            txSop_q     <= xfer && selSop && firstBeat_q;
            txEop_q     <= xfer && selEop;
            txMod_q     <= (xfer && selEop) ? selMod : '0;
            if (xfer) begin
                txData_q <= selData;
            end
        end
    end

    assign pkt_tx_data = txData_q;
    assign pkt_tx_sop  = txSop_q;
    assign pkt_tx_eop  = txEop_q;
    assign pkt_tx_mod  = txMod_q;
    assign pkt_tx_val  = txVal_q;
    assign cur_grant   = grant_q;
    assign proto_err   = protoErr_q;

`ifdef PKT_TX_ARB_STATS_EN
    logic [STAT_W-1:0] statCnt_q [N_SRC];

    // Count completed packets per source; counters wrap naturally.
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            for (int i = 0; i < N_SRC; i++) begin
                statCnt_q[i] <= '0;
            end
        end else if (xfer && selEop) begin
            statCnt_q[grant_q] <= statCnt_q[grant_q] + STAT_W'(1);
        end
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_stat
        assign stat_pkt_cnt[g*STAT_W +: STAT_W] = statCnt_q[g];
    end
`endif

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// Self-checking bench for pkt_tx_arbiter.
// Source drivers replay queued packets; a negedge monitor turns every accepted
// beat into an expected output beat and checks the MAC side against it.
// Build with PKT_TX_ARB_STATS_EN defined to also check the packet counters.
module tb_pkt_tx_arbiter;

    localparam int N_SRC  = 2;
    localparam int DATA_W = 64;

    logic                    clk;
    logic                    reset_156m25;
    logic [N_SRC-1:0]        src_val, src_sop, src_eop, src_rdy;
    logic [N_SRC*3-1:0]      src_mod;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [DATA_W-1:0]       pkt_tx_data;
    logic                    pkt_tx_sop, pkt_tx_eop, pkt_tx_val, pkt_tx_full;
    logic [2:0]              pkt_tx_mod;
    logic [0:0]              cur_grant;
    logic                    proto_err;
`ifdef PKT_TX_ARB_STATS_EN
    logic [N_SRC*32-1:0]     stat_pkt_cnt;
`endif

    pkt_tx_arbiter #(.N_SRC(N_SRC), .DATA_W(DATA_W)) dut (
        .clk_156m25   (clk),
        .reset_156m25 (reset_156m25),
        .src_val      (src_val),
        .src_sop      (src_sop),
        .src_eop      (src_eop),
        .src_mod      (src_mod),
        .src_data     (src_data),
        .src_rdy      (src_rdy),
        .pkt_tx_data  (pkt_tx_data),
        .pkt_tx_sop   (pkt_tx_sop),
        .pkt_tx_eop   (pkt_tx_eop),
        .pkt_tx_mod   (pkt_tx_mod),
        .pkt_tx_val   (pkt_tx_val),
        .pkt_tx_full  (pkt_tx_full),
        .cur_grant    (cur_grant),
`ifdef PKT_TX_ARB_STATS_EN
        .stat_pkt_cnt (stat_pkt_cnt),
`endif
        .proto_err    (proto_err)
    );

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
    } beat_t;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        int          cyc;
    } exp_t;

    beat_t            srcQ [N_SRC][$];
    exp_t             expQ[$];
    int               ordQ[$];
    int               nVec = 0;
    int               nErr = 0;
    int               cyc = 0;
    int               accBeats = 0;
    int               lastG = N_SRC - 1;
    logic [N_SRC-1:0] accMask = '0;
    bit               inPkt [N_SRC];
    logic [31:0]      statModel [N_SRC];
    bit               gapMode = 0;
    bit               fullRand = 0;
    logic             fullCmd = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: count it, report it if the values differ.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int pending();
        int s = expQ.size();
        for (int i = 0; i < N_SRC; i++) s += srcQ[i].size();
        return s;
    endfunction

    // Queue one packet on a source and record the source in the grant order.
    task automatic applyStimulus(input int src, input int nBeats, input logic [63:0] base,
                                 input logic [2:0] mod, input bit midSop);
        beat_t b;
        for (int k = 0; k < nBeats; k++) begin
            b.data = base * 64'(k + 1);
            b.sop  = (k == 0) || (midSop && k == 1);
            b.eop  = (k == nBeats - 1);
            b.mod  = b.eop ? mod : 3'($urandom_range(0, 7));
            srcQ[src].push_back(b);
        end
        ordQ.push_back(src);
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput({name, "_drain"}, 64'(pending()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic doReset();
        @(posedge clk);
        #2 reset_156m25 = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset_156m25 = 1'b0;
    endtask

    // Source drivers: present the head of each queue, drop it once accepted.
    initial begin
        beat_t b;
        src_val = '0; src_sop = '0; src_eop = '0; src_mod = '0; src_data = '0;
        pkt_tx_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N_SRC; i++) begin
                if (accMask[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
                if (srcQ[i].size() > 0) begin
                    b = srcQ[i][0];
                    src_val[i] = (b.sop || !gapMode) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    src_sop[i] = b.sop;
                    src_eop[i] = b.eop;
                    src_mod[i*3 +: 3] = b.mod;
                    src_data[i*DATA_W +: DATA_W] = b.data;
                end else begin
                    src_val[i] = 1'b0;
                    src_sop[i] = 1'b0;
                    src_eop[i] = 1'b0;
                end
            end
            pkt_tx_full = fullRand ? ($urandom_range(0, 3) == 0) : fullCmd;
        end
    end

    // Monitor: check the MAC side, then turn newly accepted beats into expectations.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   first;
        bit   rdyOk;
        cyc++;
        if (pkt_tx_val === 1'b1) begin
            if (expQ.size() == 0) begin
                nVec++;
                nErr++;
                $display("[TB] FAIL unexpected_beat: got data 0x%0h, expected no beat at cycle %0d", pkt_tx_data, cyc);
            end else begin
                e = expQ.pop_front();
                checkOutput("beat_data", pkt_tx_data, e.data);
                checkOutput("beat_sop_eop_mod", 64'({pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}),
                            64'({e.sop, e.eop, e.mod}));
                checkOutput("beat_latency", 64'(cyc), 64'(e.cyc + 1));
            end
        end else begin
            checkOutput("idle_sop_eop", 64'({pkt_tx_val, pkt_tx_sop, pkt_tx_eop}), 64'(0));
        end
        rdyOk = pkt_tx_full ? (src_rdy == '0) : ($countones(src_rdy) <= 1);
        checkOutput("rdy_rule", 64'(rdyOk), 64'(1));
        if (reset_156m25) begin
            accMask = '0;
            lastG = N_SRC - 1;
            for (int i = 0; i < N_SRC; i++) begin
                inPkt[i] = 0;
                statModel[i] = '0;
            end
        end else begin
            accMask = src_val & src_rdy;
            for (int i = 0; i < N_SRC; i++) begin
                if (accMask[i]) begin
                    first = !inPkt[i];
                    if (first) begin
                        if (ordQ.size() == 0) begin
                            nVec++;
                            nErr++;
                            $display("[TB] FAIL grant_order: got source %0d, expected no new packet", i);
                        end else begin
                            checkOutput("grant_order", 64'(i), 64'(ordQ.pop_front()));
                        end
                    end
                    checkOutput("cur_grant", 64'(cur_grant), 64'(i));
                    e.data = src_data[i*DATA_W +: DATA_W];
                    e.sop  = src_sop[i] && first;
                    e.eop  = src_eop[i];
                    e.mod  = src_eop[i] ? src_mod[i*3 +: 3] : 3'd0;
                    e.cyc  = cyc;
                    expQ.push_back(e);
                    inPkt[i] = !src_eop[i];
                    if (src_eop[i]) begin
                        lastG = i;
                        statModel[i] = statModel[i] + 32'd1;
                    end
                    accBeats++;
                end
            end
        end
    end

    // Main sequence of scenarios.
    initial begin
        beat_t bad;
        int    a0;
        int    n;
        int    start;
        reset_156m25 = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_val", 64'(pkt_tx_val), 64'(0));
        checkOutput("rst_sop_eop", 64'({pkt_tx_sop, pkt_tx_eop}), 64'(0));
        checkOutput("rst_mod", 64'(pkt_tx_mod), 64'(0));
        checkOutput("rst_data", pkt_tx_data, 64'(0));
        checkOutput("rst_rdy", 64'(src_rdy), 64'(0));
        checkOutput("rst_cur_grant", 64'(cur_grant), 64'(0));
        checkOutput("rst_proto_err", 64'(proto_err), 64'(0));
`ifdef PKT_TX_ARB_STATS_EN
        checkOutput("rst_stat", stat_pkt_cnt, 64'(0));
`endif
        @(posedge clk);
        #2 reset_156m25 = 1'b0;

        $display("[TB] three-beat packet on source 0");
        applyStimulus(0, 3, 64'h1111_1111_1111_1111, 3'd5, 0);
        waitDrain("three_beat", 100);

        $display("[TB] single-beat packet on source 1");
        applyStimulus(1, 1, 64'hA5A5_5A5A_0F0F_F0F0, 3'd1, 0);
        waitDrain("single_beat", 100);
        checkOutput("cur_grant_single", 64'(cur_grant), 64'(1));

        $display("[TB] MAC full stall during beat 2");
        applyStimulus(0, 4, 64'h0101_0202_0303_0404, 3'd3, 0);
        a0 = accBeats;
        n = 0;
        while (accBeats == a0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("stall_first_beat", 64'(accBeats - a0), 64'(1));
        fullCmd = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkOutput("stall_rdy", 64'(src_rdy), 64'(0));
        end
        #1 fullCmd = 1'b0;
        waitDrain("stall", 100);

        $display("[TB] randomized backlogged traffic");
        gapMode = 1;
        fullRand = 1;
        start = (lastG + 1) % N_SRC;
        for (int k = 0; k < 20; k++) begin
            applyStimulus((start + k) % N_SRC, int'($urandom_range(1, 5)), {$urandom, $urandom},
                          3'($urandom_range(0, 7)), 0);
        end
        waitDrain("random", 3000);
        gapMode = 0;
        fullRand = 0;
        checkOutput("proto_after_random", 64'(proto_err), 64'(0));
`ifdef PKT_TX_ARB_STATS_EN
        checkOutput("stat_random_src0", 64'(stat_pkt_cnt[31:0]), 64'(statModel[0]));
        checkOutput("stat_random_src1", 64'(stat_pkt_cnt[63:32]), 64'(statModel[1]));
`endif

        $display("[TB] reset in the middle of a packet");
        applyStimulus(0, 5, 64'h7777_0000_0000_0001, 3'd2, 0);
        a0 = accBeats;
        n = 0;
        while (accBeats == a0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("reset_first_beat", 64'(accBeats - a0), 64'(1));
        @(posedge clk);
        #2 reset_156m25 = 1'b1;
        srcQ[0].delete();
        @(negedge clk);
        @(negedge clk);
        checkOutput("val_after_reset", 64'(pkt_tx_val), 64'(0));
        #1 reset_156m25 = 1'b0;
        applyStimulus(1, 3, 64'h0000_0000_0000_1234, 3'd6, 0);
        waitDrain("after_reset", 100);
        checkOutput("proto_after_reset", 64'(proto_err), 64'(0));

        $display("[TB] sop repeated inside a packet");
        applyStimulus(0, 3, 64'h0BAD_0000_0000_0100, 3'd4, 1);
        waitDrain("mid_sop", 100);
        checkOutput("proto_mid_sop", 64'(proto_err), 64'(1));
        doReset();
        checkOutput("proto_cleared", 64'(proto_err), 64'(0));

        $display("[TB] non-sop beat while idle, then three source 1 packets");
        bad.data = 64'hDEAD_BEEF_0000_0000;
        bad.sop  = 1'b0;
        bad.eop  = 1'b1;
        bad.mod  = 3'd3;
        srcQ[0].push_back(bad);
        repeat (4) @(negedge clk);
        checkOutput("idle_nonsop_rdy", 64'(src_rdy), 64'(0));
        checkOutput("proto_idle_nonsop", 64'(proto_err), 64'(1));
        #1 srcQ[0].delete();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, k + 1, {$urandom, $urandom}, 3'(k), 0);
        end
        waitDrain("three_src1", 200);
        checkOutput("proto_sticky", 64'(proto_err), 64'(1));
`ifdef PKT_TX_ARB_STATS_EN
        checkOutput("stat_src1", 64'(stat_pkt_cnt[63:32]), 64'(3));
        checkOutput("stat_src0", 64'(stat_pkt_cnt[31:0]), 64'(0));
`endif
        doReset();
        checkOutput("proto_final_reset", 64'(proto_err), 64'(0));
        checkOutput("cur_grant_final_reset", 64'(cur_grant), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
